dct2_transpose_buffer: RTL and testbench

//  Corner-turn memory between the two 1-D DCT-II passes. Accepts one permuted

---
 rtl/dct2_pkg.sv | 25 ++
 rtl/transpose_bank.sv | 40 ++++
 rtl/dct2_transpose_buffer.sv | 176 +++++++++++++++++
 tb/tb_dct2_transpose_buffer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct2_pkg.sv
// Shared types and helpers for the 2-D DCT-II datapath.
package dct2_pkg;

  localparam int COEF_W = 16;
  localparam int MAX_S  = 32;
  localparam int BUS_W  = MAX_S * COEF_W;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {SZ4, SZ8, SZ16, SZ32} size_e;

  // Fill/drain state of one bank of the transpose buffer.
  typedef enum logic {ST_FILL, ST_DRAIN} state_e;

  // Block dimension for a size code: 4 << code.
  function automatic logic [5:0] size_of(size_e code);
    return 6'd4 << code;
  endfunction

  // Terminal count for the 5-bit row/column counters (S-1).
  function automatic logic [4:0] last_idx(size_e code);
    return 5'(size_of(code) - 6'd1);
  endfunction

endpackage

// File: rtl/transpose_bank.sv
// One SxS corner-turn bank: row write port, column read mux.
// Rows at or beyond S read back as zero so the output pad is clean.
module transpose_bank
  import dct2_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [4:0]       wr_row,
  input  logic [BUS_W-1:0] wr_data,
  input  logic [1:0]       wr_n,
  input  logic [4:0]       rd_col,
  input  logic [1:0]       rd_n,
  output logic [BUS_W-1:0] rd_data
);

  coef_t      mem [MAX_S][MAX_S];
  logic [5:0] wr_size;
  logic [5:0] rd_size;

  assign wr_size = size_of(size_e'(wr_n));
  assign rd_size = size_of(size_e'(rd_n));

  // Row write: coefficient k sits at the MSB end of the bus, only k < S stored.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < MAX_S; k++) begin
        if (6'(k) < wr_size) mem[wr_row][k] <= wr_data[BUS_W-1-COEF_W*k -: COEF_W];
      end
    end
  end

  // Column read: element of row r placed at the MSB end, rows >= S zeroed.
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < MAX_S; r++) begin
      if (6'(r) < rd_size) rd_data[BUS_W-1-COEF_W*r -: COEF_W] = mem[r][rd_col];
    end
  end

endmodule

// File: rtl/dct2_transpose_buffer.sv
// Corner-turn buffer between the row and column 1-D DCT-II passes.
// Rows of an SxS block (S = 4<<n) are written in, then read out column by
// column in the same bus packing.
// Optional macro TRANSPOSE_PINGPONG_EN: two banks, one fills while the other
// drains; each bank carries its own size code.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_FILL  | bank accepting rows; size code latched on row 0
//  ST_DRAIN | bank full, presenting columns until out_last transfers
module dct2_transpose_buffer
  import dct2_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       n_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_row,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_col,
  output logic             out_last,
  output logic [1:0]       out_n
);

  logic             in_fire;
  logic             out_fire;
  logic [4:0]       row_cnt;
  logic [4:0]       col_cnt;
  size_e            wr_n;
  logic             row_last;
  logic             col_last;
  logic [BUS_W-1:0] col_data;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign row_last = (row_cnt == last_idx(wr_n));
  assign out_col  = out_valid ? col_data : '0;

  // Row counter: write pointer into the bank being filled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          row_cnt <= '0;
    else if (in_fire) row_cnt <= row_last ? 5'd0 : row_cnt + 5'd1;
  end

  // Column counter: read pointer into the bank being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           col_cnt <= '0;
    else if (out_fire) col_cnt <= col_last ? 5'd0 : col_cnt + 5'd1;
  end

`ifdef TRANSPOSE_PINGPONG_EN

  state_e           bank_st     [2];
  state_e           bank_st_nxt [2];
  size_e            bank_n      [2];
  logic             wr_sel;
  logic             rd_sel;
  logic [BUS_W-1:0] bank_col    [2];

  // n_in only matters on the first row; later rows use the latched code.
  assign wr_n     = (row_cnt == 5'd0) ? size_e'(n_in) : bank_n[wr_sel];
  assign col_last = (col_cnt == last_idx(bank_n[rd_sel]));
  assign col_data = bank_col[rd_sel];

  // Per-bank state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_st[0] <= ST_FILL;
      bank_st[1] <= ST_FILL;
    end else begin
      bank_st[0] <= bank_st_nxt[0];
      bank_st[1] <= bank_st_nxt[1];
    end
  end

  // Next state: a bank turns full on its last row, free on its last column.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_st_nxt[b] = bank_st[b];
      if (bank_st[b] == ST_FILL && in_fire && row_last && wr_sel == 1'(b))
        bank_st_nxt[b] = ST_DRAIN;
      if (bank_st[b] == ST_DRAIN && out_fire && col_last && rd_sel == 1'(b))
        bank_st_nxt[b] = ST_FILL;
    end
  end

  // Handshake outputs follow the write and read bank pointers.
  always_comb begin
    in_ready  = (bank_st[wr_sel] == ST_FILL) && !rst;
    out_valid = (bank_st[rd_sel] == ST_DRAIN);
    out_last  = out_valid && col_last;
    out_n     = bank_n[rd_sel];
  end

  // Bank pointers alternate A,B,A,...; size code latched per bank on row 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      bank_n[0] <= SZ4;
      bank_n[1] <= SZ4;
    end else begin
      if (in_fire && row_cnt == 5'd0) bank_n[wr_sel] <= size_e'(n_in);
      if (in_fire && row_last)        wr_sel <= ~wr_sel;
      if (out_fire && col_last)       rd_sel <= ~rd_sel;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    transpose_bank u_bank (
      .clk     (clk),
      .we      (in_fire && (wr_sel == 1'(b))),
      .wr_row  (row_cnt),
      .wr_data (in_row),
      .wr_n    (wr_n),
      .rd_col  (col_cnt),
      .rd_n    (bank_n[b]),
      .rd_data (bank_col[b])
    );
  end

`else

  state_e state;
  state_e state_nxt;
  size_e  blk_n;

  assign wr_n     = (row_cnt == 5'd0) ? size_e'(n_in) : blk_n;
  assign col_last = (col_cnt == last_idx(blk_n));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FILL;
    else     state <= state_nxt;
  end

  // Next state: fill until the last row, drain until the last column.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL:  if (in_fire && row_last)  state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_fire && col_last) state_nxt = ST_FILL;
      default:  state_nxt = ST_FILL;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state == ST_FILL) && !rst;
    out_valid = (state == ST_DRAIN);
    out_last  = out_valid && col_last;
    out_n     = blk_n;
  end

  // Block size latched on the first row of each block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              blk_n <= SZ4;
    else if (in_fire && row_cnt == 5'd0)  blk_n <= size_e'(n_in);
  end

  transpose_bank u_bank (
    .clk     (clk),
    .we      (in_fire),
    .wr_row  (row_cnt),
    .wr_data (in_row),
    .wr_n    (wr_n),
    .rd_col  (col_cnt),
    .rd_n    (blk_n),
    .rd_data (col_data)
  );

`endif

endmodule

// File: tb/tb_dct2_transpose_buffer.sv
// Scoreboard bench for dct2_transpose_buffer: stimulus pushes expected
// columns, a negedge monitor pops and compares on every column transfer.
module tb_dct2_transpose_buffer;
  import dct2_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       n_in = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [BUS_W-1:0] in_row = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [BUS_W-1:0] out_col;
  logic             out_last;
  logic [1:0]       out_n;

  dct2_transpose_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .n_in      (n_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_last  (out_last),
    .out_n     (out_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BUS_W-1:0] col;
    logic             last;
    logic [1:0]       n;
  } exp_t;

  exp_t  exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    n_cols = 0;
  int    stall_cnt = 0;
  int    cyc = 0;
  int    last_out_cyc = 0;
  coef_t rows [MAX_S][MAX_S];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: compare each transferred column, and hold-stability while stalled.
  exp_t             e;
  logic             stalled = 1'b0;
  logic [BUS_W-1:0] st_col;
  logic             st_last;
  logic [1:0]       st_n;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_col", out_col, st_col);
        chk("stall_last", out_last, st_last);
        chk("stall_n", out_n, st_n);
      end
      if (out_valid && out_ready) begin
        n_cols++;
        last_out_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_col: actual column %0h with none expected", out_col);
        end else begin
          e = exp_q.pop_front();
          chk("col_data", out_col, e.col);
          chk("col_last", out_last, e.last);
          chk("col_n", out_n, e.n);
        end
      end
      stalled = out_valid && !out_ready;
      st_col  = out_col;
      st_last = out_last;
      st_n    = out_n;
    end
  end

  function automatic logic [BUS_W-1:0] pack_row(input int r);
    logic [BUS_W-1:0] v = '0;
    for (int k = 0; k < MAX_S; k++) v[BUS_W-1-COEF_W*k -: COEF_W] = rows[r][k];
    return v;
  endfunction

  // Reference transpose of rows[ro .. ro+S-1].
  task automatic push_block(input logic [1:0] n, input int ro);
    int   s = 4 << n;
    exp_t x;
    for (int c = 0; c < s; c++) begin
      x.col = '0;
      for (int r = 0; r < s; r++) x.col[BUS_W-1-COEF_W*r -: COEF_W] = rows[ro+r][c];
      x.last = (c == s - 1);
      x.n    = n;
      exp_q.push_back(x);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the row transferred.
  task automatic send_row(input logic [1:0] n, input int r);
    int   t = 0;
    logic rdy;
    n_in     = n;
    in_row   = pack_row(r);
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      stall_cnt++;
      t++;
      if (t > 300) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_row_timeout: row %0d not accepted, in_ready %0b required 1", r, in_ready);
        break;
      end
    end
  endtask

  task automatic send_block(input logic [1:0] n0, input logic [1:0] nrest, input int ro);
    int s = 4 << n0;
    for (int r = 0; r < s; r++) send_row((r == 0) ? n0 : nrest, ro + r);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d columns outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int               base;
    int               t;
    int               cnt;
    int               t0;
    logic [15:0]      pat;
    exp_t             x;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_out_n", out_n, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // 1: 4x4, coef k of row r = 16r+k; column c row r = 16r+c, pad zero.
    for (int r = 0; r < MAX_S; r++)
      for (int k = 0; k < MAX_S; k++) rows[r][k] = coef_t'(16 * r + k);
    for (int c = 0; c < 4; c++) begin
      x.col = '0;
      for (int r = 0; r < 4; r++) x.col[BUS_W-1-COEF_W*r -: COEF_W] = 16'(16 * r + c);
      x.last = (c == 3);
      x.n    = 2'd0;
      exp_q.push_back(x);
    end
    send_block(2'd0, 2'd0, 0);
    wait_empty();

    // 2: 32x32 random incl. extremes; latency 1 and 32 back-to-back columns.
    for (int r = 0; r < MAX_S; r++)
      for (int k = 0; k < MAX_S; k++) rows[r][k] = coef_t'($urandom);
    rows[0][0]   = 16'h8000;
    rows[31][31] = 16'h7FFF;
    rows[3][17]  = 16'h8000;
    rows[17][3]  = 16'h7FFF;
    push_block(2'd3, 0);
    send_block(2'd3, 2'd3, 0);
    @(negedge clk);
    chk("latency_first_col", out_valid, 1);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      cnt += int'(out_valid);
    end
    chk("consecutive_valid", cnt, 32);
    @(negedge clk);
    chk("valid_after_32", out_valid, 0);
    @(posedge clk);
    #1;
    wait_empty();

    // 3: 8x8 with pseudo-random backpressure.
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < MAX_S; k++) rows[r][k] = coef_t'(-(32 * r + k) - 1);
    push_block(2'd1, 0);
    base = n_cols;
    send_block(2'd1, 2'd1, 0);
    pat = 16'b1010_0110_1100_0101;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      out_ready = pat[t % 16];
      @(posedge clk);
      #1;
      t++;
    end
    out_ready = 1'b1;
    wait_empty();
    chk("bp_col_count", n_cols - base, 8);

    // 4: size changes after row 0 are ignored.
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < MAX_S; k++) rows[r][k] = coef_t'(16'h1000 + 32 * r + k);
    push_block(2'd1, 0);
    base = n_cols;
    send_block(2'd1, 2'd3, 0);
    wait_empty();
    chk("midsize_col_count", n_cols - base, 8);
    @(negedge clk);
    chk("midsize_fill_again", in_ready, 1);
    chk("midsize_idle", out_valid, 0);
    @(posedge clk);
    #1;

    // 5: reset while column 5 of a 16x16 block is presented.
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < MAX_S; k++) rows[r][k] = coef_t'($urandom);
    push_block(2'd2, 0);
    base = n_cols;
    send_block(2'd2, 2'd2, 0);
    t = 0;
    while (n_cols < base + 5 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("abort_at_col5", n_cols - base, 5);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_last", out_last, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_no_col", out_valid, 0);
    @(posedge clk);
    #1;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < MAX_S; k++) rows[r][k] = coef_t'(16'hA000 + 16 * r + k);
    push_block(2'd0, 0);
    send_block(2'd0, 2'd0, 0);
    wait_empty();

    // 6: two 8x8 blocks back to back with in_valid and out_ready held high.
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < MAX_S; k++) rows[r][k] = coef_t'(16'h3000 + 32 * r + k);
    push_block(2'd1, 0);
    push_block(2'd1, 8);
    stall_cnt = 0;
    t0 = cyc;
    for (int r = 0; r < 16; r++) send_row(2'd1, r);
    in_valid = 1'b0;
    wait_empty();
`ifdef TRANSPOSE_PINGPONG_EN
    chk("pp_in_ready_stalls", stall_cnt, 0);
    chk("b2b_last_col_cycle", last_out_cyc - t0, 23);
`else
    chk("b2b_in_ready_stalls", stall_cnt, 8);
    chk("b2b_last_col_cycle", last_out_cyc - t0, 31);
`endif
    chk("b2b_all_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
